aes_iter_cipher_core: RTL and testbench
=======================================

# aes_iter_cipher_core

Iterative AES block cipher core executing one round per clock, in encrypt or decrypt direction selected per block, with optional XEX tweak whitening for XTS use. It sits between the sector/tweak controller and the external round-key store, replacing chains of unrolled combinational round functions with a single registered round datapath. Round count is parametrised for AES-128/192/256.

## Interface

- NR, 14, number of rounds; legal values 10, 12, 14, anything else is an elaboration error
- TWEAK_EN, 1, 1 = XOR inTweak into the state before the first AddRoundKey and into the result after the last; 0 = inTweak ignored
- inClk  in  1  clock, rising edge
- inRst  in  1  reset; one clock, asynchronous, active-high
- inData  in  128  plaintext (encrypt) or ciphertext (decrypt)
- inTweak  in  128  XEX tweak, sampled with inData
- inDecrypt  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- inValid  in  1  input block valid
- outReady  out  1  core can accept a block
- outKeyIdx  out  4  round-key index requested this cycle
- inRoundKey  in  128  round key for outKeyIdx, returned combinationally in the same cycle
- outData  out  128  result block
- outValid  out  1  result valid
- inReady  in  1  downstream accepts result

## Operation

- FSM states: IDLE, RUN, DONE. Reset value: IDLE, state register 0, round counter 0, outValid 0, outData 0.
- IDLE: outReady=1; outKeyIdx = inDecrypt ? NR : 0. On inValid&&outReady: latch mode and tweak; state <= (inData ^ tweak') ^ inRoundKey (tweak' = inTweak if TWEAK_EN else 0); round counter <= 1; go RUN.
- RUN: outReady=0; outKeyIdx = encrypt ? r : NR-r.
  - Encrypt, r<NR: state <= MixColumns(ShiftRows(SubBytes(state))) ^ key.
  - Decrypt, r<NR: state <= InvMixColumns(InvShiftRows(InvSubBytes(state)) ^ key).
  - r=NR: MixColumns/InvMixColumns omitted; state <= round result ^ tweak'; go DONE.
  - r increments by 1 each RUN cycle, width 4, never wraps (max 14).
- DONE: outValid=1, outData = state, held stable until inReady. On inValid... ignored; on inValid&&... no input accepted in DONE. On outValid&&inReady: outValid <= 0, go IDLE.
- outKeyIdx in DONE: 0 (don't-care for key store).
- Mode and tweak changes on inputs while RUN/DONE have no effect.
- inRst asserted mid-block: immediate return to IDLE, block discarded, outValid drops asynchronously, no partial result ever presented.

## Timing

- Latency: accept edge k; result registered at edge k+NR; outValid high from k+NR to handshake edge. NR=14: 14 edges after accept (15 cycles including accept cycle).
- Throughput: one block per NR+2 cycles with inReady held high (accept, NR rounds, one DONE cycle; IDLE re-entered before next accept).
- inRoundKey path is combinational from outKeyIdx; key store must meet single-cycle read.
- outData changes only on the edge entering DONE or on reset.

## Structure

- Package aes_pkg: NR_128=10, NR_192=12, NR_256=14 constants; KEY_IDX_W=4; FSM state enum {IDLE, RUN, DONE}; 128-bit block typedef.
- One sub-module aes_round_datapath: combinational, inputs state, key, decrypt, lastRound; output next state. Built from the existing AesSubBytesFun, AesShiftRowsFun, AesMixColumnsFun, AesInvSubBytesFun, AesInvShiftRowsFun, AesInvMixColumnsFun, AesAddRoundKeyFun.
- Top holds FSM, round counter, state register, key index generation, tweak register.

## Test plan

- NR=14, TWEAK_EN=0, key 000102…1f (schedule from model), encrypt 00112233445566778899aabbccddeeff -> outData 8ea2b7ca516745bfeafc49904b496089 exactly 14 edges after accept; outKeyIdx sequence 0,1,…,14.
- Same key, decrypt 8ea2b7ca516745bfeafc49904b496089 -> 00112233445566778899aabbccddeeff; outKeyIdx sequence 14,13,…,0.
- NR=10, key 000102…0f, encrypt same plaintext -> 69c4e0d86a7b0430d8cdb78070b4c55a after 10 edges.
- TWEAK_EN=1, tweak 0x01 (LSB), random data: outData == model E(P^T)^T; decrypt of result with same tweak returns P.
- Backpressure: inReady low 5 cycles in DONE -> outValid/outData held, outReady stays 0, inValid pulses ignored; next block accepted only after handshake and return to IDLE.
- inRst pulsed at round 7 -> outValid 0, outReady 1 next cycle; following block produces correct result with no residue.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES constants, types and round-function helpers
package aes_pkg;

  localparam int NR_128    = 10;
  localparam int NR_192    = 12;
  localparam int NR_256    = 14;
  localparam int KEY_IDX_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_e;
  typedef logic [127:0] aes_block_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 via a short addition chain; 0 maps to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2;
    logic [7:0] a3;
    logic [7:0] a12;
    logic [7:0] a15;
    logic [7:0] a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a12  = gf_mul(a3, a3);
    a12  = gf_mul(a12, a12);
    a15  = gf_mul(a12, a3);
    a240 = a15;
    for (int i = 0; i < 4; i++) a240 = gf_mul(a240, a240);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    x = gf_inv(b);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction

  function automatic aes_block_t AesSubBytesFun(input aes_block_t s);
    aes_block_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  function automatic aes_block_t AesInvSubBytesFun(input aes_block_t s);
    aes_block_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Byte 0 is the most significant; byte 4*c+w sits in column c, row w.
  function automatic aes_block_t AesShiftRowsFun(input aes_block_t s);
    aes_block_t r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic aes_block_t AesInvShiftRowsFun(input aes_block_t s);
    aes_block_t r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+4-w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {gf_xtime(a0) ^ gf_xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ gf_xtime(a1) ^ gf_xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ gf_xtime(a2) ^ gf_xtime(a3) ^ a3,
            gf_xtime(a0) ^ a0 ^ a1 ^ a2 ^ gf_xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11) ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9),
            gf_mul(a0, 8'd9)  ^ gf_mul(a1, 8'd14) ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13),
            gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9)  ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11),
            gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13) ^ gf_mul(a2, 8'd9)  ^ gf_mul(a3, 8'd14)};
  endfunction

  function automatic aes_block_t AesMixColumnsFun(input aes_block_t s);
    aes_block_t r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return r;
  endfunction

  function automatic aes_block_t AesInvMixColumnsFun(input aes_block_t s);
    aes_block_t r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return r;
  endfunction

  function automatic aes_block_t AesAddRoundKeyFun(input aes_block_t s, input aes_block_t k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_round_datapath.sv
// rtl/aes_round_datapath.sv - one combinational AES round, encrypt or decrypt
module aes_round_datapath
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic         decrypt_i,
  input  logic         last_round_i,
  output logic [127:0] next_o
);

  logic [127:0] enc_sr;
  logic [127:0] enc_out;
  logic [127:0] dec_ark;
  logic [127:0] dec_out;

  assign enc_sr  = AesShiftRowsFun(AesSubBytesFun(state_i));
  assign enc_out = AesAddRoundKeyFun(last_round_i ? enc_sr : AesMixColumnsFun(enc_sr), key_i);

  // Standard inverse cipher: the round key is added before InvMixColumns.
  assign dec_ark = AesAddRoundKeyFun(AesInvSubBytesFun(AesInvShiftRowsFun(state_i)), key_i);
  assign dec_out = last_round_i ? dec_ark : AesInvMixColumnsFun(dec_ark);

  assign next_o = decrypt_i ? dec_out : enc_out;

endmodule

// File: rtl/aes_iter_cipher_core.sv
// rtl/aes_iter_cipher_core.sv - iterative AES core, one round per clock, optional XEX whitening
module aes_iter_cipher_core
  import aes_pkg::*;
#(
  parameter int NR       = NR_256,
  parameter bit TWEAK_EN = 1'b1
) (
  input  logic         inClk,
  input  logic         inRst,
  input  logic [127:0] inData,
  input  logic [127:0] inTweak,
  input  logic         inDecrypt,
  input  logic         inValid,
  output logic         outReady,
  output logic [3:0]   outKeyIdx,
  input  logic [127:0] inRoundKey,
  output logic [127:0] outData,
  output logic         outValid,
  input  logic         inReady
);

  if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_bad_nr
    $error("aes_iter_cipher_core: NR must be 10, 12 or 14");
  end

  localparam logic [KEY_IDX_W-1:0] LAST_IDX = KEY_IDX_W'(NR);

  aes_state_e           fsm_q;
  logic [KEY_IDX_W-1:0] round_q;
  logic [KEY_IDX_W-1:0] key_idx;
  logic [127:0]         state_q;
  logic [127:0]         state_d;
  logic [127:0]         tweak_q;
  logic [127:0]         tweak_in;
  logic [127:0]         out_data_q;
  logic                 decrypt_q;
  logic                 out_valid_q;
  logic                 last_round;

  assign tweak_in   = TWEAK_EN ? inTweak : '0;
  assign last_round = (round_q == LAST_IDX);

  // Key index is combinational so the key store can answer within the same cycle.
  always_comb begin
    key_idx = '0;
    case (fsm_q)
      IDLE:    key_idx = inDecrypt ? LAST_IDX : '0;
      RUN:     key_idx = decrypt_q ? (LAST_IDX - round_q) : round_q;
      default: key_idx = '0;
    endcase
  end

  aes_round_datapath u_round (
    .state_i      (state_q),
    .key_i        (inRoundKey),
    .decrypt_i    (decrypt_q),
    .last_round_i (last_round),
    .next_o       (state_d)
  );

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      fsm_q       <= IDLE;
      round_q     <= '0;
      state_q     <= '0;
      tweak_q     <= '0;
      decrypt_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (inValid) begin
            decrypt_q <= inDecrypt;
            tweak_q   <= tweak_in;
            state_q   <= AesAddRoundKeyFun(inData ^ tweak_in, inRoundKey);
            round_q   <= KEY_IDX_W'(1);
            fsm_q     <= RUN;
          end
        end
        RUN: begin
          if (last_round) begin
            state_q     <= state_d ^ tweak_q;
            out_data_q  <= state_d ^ tweak_q;
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            state_q <= state_d;
            round_q <= round_q + 1'b1;
          end
        end
        DONE: begin
          if (inReady) begin
            out_valid_q <= 1'b0;
            fsm_q       <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign outReady  = (fsm_q == IDLE);
  assign outKeyIdx = key_idx;
  assign outData   = out_data_q;
  assign outValid  = out_valid_q;

endmodule

// File: tb/tb_aes_iter_cipher_core.sv
// tb/tb_aes_iter_cipher_core.sv - scoreboard bench for aes_iter_cipher_core
module tb_aes_iter_cipher_core;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel10 = 1'b0;
  logic [127:0] in_data = '0;
  logic [127:0] in_tweak = '0;
  logic         in_dec = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready = 1'b1;

  logic         ready14, ready10, ov14, ov10;
  logic [3:0]   kidx14, kidx10;
  logic [127:0] od14, od10, key14, key10;
  logic         out_ready, out_valid;
  logic [3:0]   kidx;
  logic [127:0] out_data;

  logic [7:0]   sb [256];
  logic [127:0] rk14 [16];
  logic [127:0] rk10 [16];
  logic [127:0] exp_q [$];
  int           n_vec = 0;
  int           n_miss = 0;

  always #5 clk = ~clk;

  assign key14     = rk14[kidx14];
  assign key10     = rk10[kidx10];
  assign out_ready = sel10 ? ready10 : ready14;
  assign out_valid = sel10 ? ov10 : ov14;
  assign out_data  = sel10 ? od10 : od14;
  assign kidx      = sel10 ? kidx10 : kidx14;

  aes_iter_cipher_core #(.NR(14), .TWEAK_EN(1'b1)) u_dut14 (
    .inClk(clk), .inRst(rst), .inData(in_data), .inTweak(in_tweak), .inDecrypt(in_dec),
    .inValid(in_valid & ~sel10), .outReady(ready14), .outKeyIdx(kidx14), .inRoundKey(key14),
    .outData(od14), .outValid(ov14), .inReady(in_ready & ~sel10)
  );

  aes_iter_cipher_core #(.NR(10), .TWEAK_EN(1'b0)) u_dut10 (
    .inClk(clk), .inRst(rst), .inData(in_data), .inTweak(in_tweak), .inDecrypt(in_dec),
    .inValid(in_valid & sel10), .outReady(ready10), .outKeyIdx(kidx10), .inRoundKey(key10),
    .outData(od10), .outValid(ov10), .inReady(in_ready & sel10)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference AES encryption built on a generated S-box table.
  function automatic logic [7:0] rl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic void gen_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_w(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int j);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4*(j+1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) t = sub_w(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [255:0] key,
                                           input int nk, input int nr);
    logic [127:0] s, r;
    logic [7:0]   a [4];
    s = p ^ round_key(key, nk, 0);
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sb[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      s = r;
      if (rnd < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
          for (int w = 0; w < 4; w++)
            r[127-8*(4*c+w) -: 8] = xt(a[w]) ^ xt(a[(w+1)%4]) ^ a[(w+1)%4] ^ a[(w+2)%4] ^ a[(w+3)%4];
        end
        s = r;
      end
      s = s ^ round_key(key, nk, rnd);
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Pops the scoreboard on every result handshake the DUT is about to take.
  always begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && in_ready) begin
      if (exp_q.size() == 0) check_eq("sb_unexpected", 128'(out_valid), 128'h0);
      else check_eq("sb_data", out_data, exp_q.pop_front());
    end
  end

  task automatic run_block(input logic [127:0] d, input logic [127:0] t, input logic dec,
                           input logic [127:0] exp, input int nr, input int hold);
    int n;
    n = 0;
    while (!out_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("accept_ready", 128'(out_ready), 128'h1);
    exp_q.push_back(exp);
    in_ready = (hold == 0);
    in_data  = d;
    in_tweak = t;
    in_dec   = dec;
    in_valid = 1'b1;
    #1 check_eq("kidx_accept", 128'(kidx), dec ? 128'(nr) : 128'h0);
    tick();
    in_valid = 1'b0;
    in_dec   = ~dec;
    in_data  = rnd128();
    in_tweak = rnd128();
    for (int r = 1; r <= nr; r++) begin
      check_eq("kidx_run", 128'(kidx), dec ? 128'(nr - r) : 128'(r));
      check_eq("run_valid", 128'(out_valid), 128'h0);
      check_eq("run_ready", 128'(out_ready), 128'h0);
      tick();
    end
    check_eq("latency_valid", 128'(out_valid), 128'h1);
    for (int h = 0; h < hold; h++) begin
      check_eq("bp_valid", 128'(out_valid), 128'h1);
      check_eq("bp_ready", 128'(out_ready), 128'h0);
      check_eq("bp_data", out_data, exp);
      in_valid = 1'b1;
      in_data  = rnd128();
      tick();
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    tick();
    check_eq("post_valid", 128'(out_valid), 128'h0);
    check_eq("post_ready", 128'(out_ready), 128'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p, t, e;
    gen_sbox();
    for (int j = 0; j < 16; j++) begin
      rk14[j] = (j <= 14) ? round_key(K256, 8, j) : '0;
      rk10[j] = (j <= 10) ? round_key(K128, 4, j) : '0;
    end

    repeat (3) tick();
    check_eq("rst_held_valid", 128'(out_valid), 128'h0);
    check_eq("rst_held_data", out_data, 128'h0);
    rst = 1'b0;
    tick();
    check_eq("reset_valid14", 128'(ov14), 128'h0);
    check_eq("reset_valid10", 128'(ov10), 128'h0);
    check_eq("reset_ready14", 128'(ready14), 128'h1);
    check_eq("reset_data14", od14, 128'h0);
    check_eq("reset_data10", od10, 128'h0);
    check_eq("idle_kidx_enc", 128'(kidx), 128'h0);
    in_dec = 1'b1;
    #1 check_eq("idle_kidx_dec", 128'(kidx), 128'd14);
    in_dec = 1'b0;

    run_block(PT, '0, 1'b0, CT256, 14, 0);
    run_block(CT256, '0, 1'b1, PT, 14, 0);

    sel10 = 1'b1;
    run_block(PT, rnd128(), 1'b0, CT128, 10, 0);
    run_block(CT128, rnd128(), 1'b1, PT, 10, 0);
    sel10 = 1'b0;

    for (int i = 0; i < 3; i++) begin
      p = rnd128();
      t = (i == 0) ? 128'h1 : rnd128();
      e = aes_enc(p ^ t, K256, 8, 14) ^ t;
      run_block(p, t, 1'b0, e, 14, 0);
      run_block(e, t, 1'b1, p, 14, 0);
    end

    run_block(PT, '0, 1'b0, CT256, 14, 5);

    in_data  = PT;
    in_tweak = '0;
    in_dec   = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check_eq("mid_kidx", 128'(kidx), 128'd7);
    rst = 1'b1;
    #1;
    check_eq("rst_async_valid", 128'(out_valid), 128'h0);
    check_eq("rst_async_ready", 128'(out_ready), 128'h1);
    tick();
    rst = 1'b0;
    check_eq("rst_data", out_data, 128'h0);
    tick();
    check_eq("after_rst_ready", 128'(out_ready), 128'h1);
    check_eq("after_rst_valid", 128'(out_valid), 128'h0);
    run_block(PT, '0, 1'b0, CT256, 14, 0);

    repeat (2) tick();
    check_eq("sb_drained", 128'(exp_q.size()), 128'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
